// File: rtl/rv32i_single_cycle_core.sv
// rtl/rv32i_single_cycle_core.sv - single-cycle RV32I integer core
module rv32i_single_cycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [31:0] read_data,
    output logic [31:0] pc,
    output logic [31:0] memory_address,
    output logic [31:0] data_to_write,
    output logic [2:0]  func3,
    output logic        write_data
);
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6f;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;

    logic [31:0] pc_q, pc_d;
    logic [31:0] regs_q [32];
    logic [31:0] rs1_val, rs2_val, imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] alu_res, rd_val, pc_plus4;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        rd_we, taken;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;

    function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] f, input logic alt);
        case (f)
            3'b000:  alu = alt ? a - b : a + b;
            3'b001:  alu = a << b[4:0];
            3'b010:  alu = {31'b0, $signed(a) < $signed(b)};
            3'b011:  alu = {31'b0, a < b};
            3'b100:  alu = a ^ b;
            3'b101:  alu = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'b110:  alu = a | b;
            default: alu = a & b;
        endcase
    endfunction

    assign opcode   = instruction[6:0];
    assign rd       = instruction[11:7];
    assign func3    = instruction[14:12];
    assign rs1      = instruction[19:15];
    assign rs2      = instruction[24:20];
    assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1];
    assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2];
    assign imm_i    = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_s    = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b    = {{19{instruction[31]}}, instruction[31], instruction[7],
                       instruction[30:25], instruction[11:8], 1'b0};
    assign imm_u    = {instruction[31:12], 12'b0};
    assign imm_j    = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                       instruction[20], instruction[30:21], 1'b0};
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        alu_res    = rs1_val + imm_i;
        rd_val     = '0;
        rd_we      = 1'b0;
        pc_d       = pc_plus4;
        write_data = 1'b0;
        taken      = 1'b0;
        ld_byte    = '0;
        ld_half    = '0;
        case (opcode)
            OP_REG: begin
                alu_res = alu(rs1_val, rs2_val, func3, instruction[30]);
                rd_val  = alu_res;
                rd_we   = 1'b1;
            end
            OP_IMM: begin
                // instruction[30] only selects SRAI; ADDI never subtracts
                alu_res = alu(rs1_val, imm_i, func3, (func3 == 3'b101) && instruction[30]);
                rd_val  = alu_res;
                rd_we   = 1'b1;
            end
            OP_LUI: begin
                alu_res = imm_u;
                rd_val  = alu_res;
                rd_we   = 1'b1;
            end
            OP_AUIPC: begin
                alu_res = pc_q + imm_u;
                rd_val  = alu_res;
                rd_we   = 1'b1;
            end
            OP_JAL: begin
                alu_res = pc_q + imm_j;
                pc_d    = alu_res;
                rd_val  = pc_plus4;
                rd_we   = 1'b1;
            end
            OP_JALR: begin
                if (func3 == 3'b000) begin
                    pc_d   = alu_res & ~32'd1;
                    rd_val = pc_plus4;
                    rd_we  = 1'b1;
                end
            end
            OP_BRANCH: begin
                alu_res = rs1_val - rs2_val;
                case (func3)
                    3'b000:  taken = rs1_val == rs2_val;
                    3'b001:  taken = rs1_val != rs2_val;
                    3'b100:  taken = $signed(rs1_val) <  $signed(rs2_val);
                    3'b101:  taken = $signed(rs1_val) >= $signed(rs2_val);
                    3'b110:  taken = rs1_val <  rs2_val;
                    3'b111:  taken = rs1_val >= rs2_val;
                    default: taken = 1'b0;
                endcase
                if (taken) pc_d = pc_q + imm_b;
            end
            OP_LOAD: begin
                case (alu_res[1:0])
                    2'd0:    ld_byte = read_data[7:0];
                    2'd1:    ld_byte = read_data[15:8];
                    2'd2:    ld_byte = read_data[23:16];
                    default: ld_byte = read_data[31:24];
                endcase
                ld_half = alu_res[1] ? read_data[31:16] : read_data[15:0];
                rd_we   = 1'b1;
                case (func3)
                    3'b000:  rd_val = {{24{ld_byte[7]}}, ld_byte};
                    3'b001:  rd_val = {{16{ld_half[15]}}, ld_half};
                    3'b010:  rd_val = read_data;
                    3'b100:  rd_val = {24'b0, ld_byte};
                    3'b101:  rd_val = {16'b0, ld_half};
                    default: rd_we  = 1'b0;
                endcase
            end
            OP_STORE: begin
                alu_res    = rs1_val + imm_s;
                write_data = !func3[2] && (func3[1:0] != 2'b11) && !reset;
            end
            default: ;
        endcase
    end

    assign memory_address = alu_res;
    assign data_to_write  = rs2_val;
    assign pc             = pc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else begin
            pc_q <= pc_d;
            if (rd_we && (rd != 5'd0)) regs_q[rd] <= rd_val;
        end
    end
endmodule

// File: tb/tb_rv32i_single_cycle_core.sv
// tb/tb_rv32i_single_cycle_core.sv - directed scoreboard bench for rv32i_single_cycle_core
module tb_rv32i_single_cycle_core;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction, read_data;
    logic [31:0] pc, memory_address, data_to_write;
    logic [2:0]  func3;
    logic        write_data;

    localparam int K_PC = 0, K_ADDR = 1, K_DTW = 2, K_WE = 3, K_F3 = 4;

    typedef struct {
        int          kind;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0, errors = 0;
    logic [31:0] exp_pc;

    rv32i_single_cycle_core #(.RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .instruction(instruction), .read_data(read_data),
        .pc(pc), .memory_address(memory_address), .data_to_write(data_to_write),
        .func3(func3), .write_data(write_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    task automatic expect_v(input int kind, input logic [31:0] val, input string tag);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.tag  = tag;
        sb_q.push_back(e);
    endtask

    task automatic compare_all();
        exp_t        e;
        logic [31:0] obs;
        @(negedge clk);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.kind)
                K_PC:    obs = pc;
                K_ADDR:  obs = memory_address;
                K_DTW:   obs = data_to_write;
                K_WE:    obs = {31'b0, write_data};
                default: obs = {29'b0, func3};
            endcase
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic stepj(input logic [31:0] ins, input string tag, input logic [31:0] nxt);
        instruction = ins;
        expect_v(K_PC, exp_pc, {tag, "_pc"});
        compare_all();
        @(posedge clk);
        #1;
        exp_pc = nxt;
    endtask

    task automatic step(input logic [31:0] ins, input string tag);
        stepj(ins, tag, exp_pc + 32'd4);
    endtask

    task automatic load_check(input logic [2:0] f3, input logic [31:0] off,
                              input logic [31:0] val, input string tag);
        expect_v(K_ADDR, 32'h100 + off, {tag, "_addr"});
        expect_v(K_F3, {29'b0, f3}, {tag, "_f3"});
        expect_v(K_WE, 32'd0, {tag, "_we"});
        step(enc_i(off, 5'd3, f3, 5'd4, 7'h03), tag);
        expect_v(K_DTW, val, {tag, "_val"});
        step(enc_s(32'd0, 5'd4, 5'd0, 3'b010), {tag, "_sw"});
    endtask

    initial begin
        reset       = 1'b1;
        instruction = enc_s(32'd0, 5'd2, 5'd0, 3'b010);
        read_data   = 32'h0;
        expect_v(K_WE, 32'd0, "reset_we");
        compare_all();
        @(posedge clk);
        #1;
        reset  = 1'b0;
        exp_pc = 32'h0;

        // basic add / negative immediate, result observed through a store
        step(enc_i(32'd5, 5'd0, 3'b000, 5'd1, 7'h13), "addi_x1");
        expect_v(K_ADDR, 32'hFFFF_FFFE, "addi_x2_alu");
        step(enc_i(-32'sd7, 5'd1, 3'b000, 5'd2, 7'h13), "addi_x2");
        expect_v(K_DTW, 32'hFFFF_FFFE, "sw_x2_data");
        expect_v(K_WE, 32'd1, "sw_x2_we");
        step(enc_s(32'd0, 5'd2, 5'd0, 3'b010), "sw_x2");

        // pass signature
        step(enc_i(32'd1, 5'd0, 3'b000, 5'd5, 7'h13), "addi_x5");
        expect_v(K_ADDR, 32'hFFFF_FFFF, "sig_addr");
        expect_v(K_F3, 32'd0, "sig_f3");
        expect_v(K_WE, 32'd1, "sig_we");
        expect_v(K_DTW, 32'd1, "sig_data");
        step(enc_s(-32'sd1, 5'd5, 5'd0, 3'b000), "sig_sb");

        // loads from base 0x100
        step(enc_i(32'h100, 5'd0, 3'b000, 5'd3, 7'h13), "addi_x3");
        read_data = 32'h8081_7F02;
        load_check(3'b000, 32'd1, 32'h0000_007F, "lb_101");
        load_check(3'b000, 32'd3, 32'hFFFF_FF80, "lb_103");
        load_check(3'b100, 32'd3, 32'h0000_0080, "lbu_103");
        load_check(3'b001, 32'd2, 32'hFFFF_8081, "lh_102");
        load_check(3'b010, 32'd0, 32'h8081_7F02, "lw_100");
        load_check(3'b101, 32'd2, 32'h0000_8081, "lhu_102");
        read_data = 32'h0;

        // branches
        step(enc_b(32'd8, 5'd0, 5'd0, 3'b001), "bne_nt");
        step(enc_i(-32'sd1, 5'd0, 3'b000, 5'd6, 7'h13), "addi_x6");
        step(enc_i(32'd1, 5'd0, 3'b000, 5'd7, 7'h13), "addi_x7");
        stepj(enc_b(32'd8, 5'd7, 5'd6, 3'b100), "blt_t", exp_pc + 32'd8);
        step(enc_b(32'd8, 5'd7, 5'd6, 3'b110), "bltu_nt");
        step(enc_b(32'd8, 5'd7, 5'd6, 3'b101), "bge_nt");
        stepj(enc_b(-32'sd4, 5'd7, 5'd6, 3'b111), "bgeu_back", exp_pc - 32'd4);
        stepj(enc_b(32'd12, 5'd7, 5'd7, 3'b000), "beq_t", exp_pc + 32'd12);

        // jumps
        stepj(enc_i(32'h20, 5'd0, 3'b000, 5'd0, 7'h67), "jalr_20", 32'h20);
        stepj(enc_j(32'd16, 5'd1), "jal_16", 32'h30);
        expect_v(K_DTW, 32'h24, "jal_link");
        step(enc_s(32'd0, 5'd1, 5'd0, 3'b010), "sw_x1");
        stepj(enc_i(32'd3, 5'd1, 3'b000, 5'd0, 7'h67), "jalr_3", 32'h26);

        // shifts, compares, writes to x0
        expect_v(K_ADDR, 32'h8000_0000, "lui_val");
        step(enc_u(20'h80000, 5'd8, 7'h37), "lui_x8");
        step(enc_i(32'd4, 5'd0, 3'b000, 5'd9, 7'h13), "addi_x9");
        expect_v(K_ADDR, 32'hF800_0000, "sra_val");
        step(enc_r(7'h20, 5'd9, 5'd8, 3'b101, 5'd10), "sra");
        expect_v(K_ADDR, 32'h0800_0000, "srl_val");
        step(enc_r(7'h00, 5'd9, 5'd8, 3'b101, 5'd10), "srl");
        expect_v(K_ADDR, 32'hF800_0000, "srai_val");
        step(enc_i(32'h404, 5'd8, 3'b101, 5'd10, 7'h13), "srai");
        expect_v(K_ADDR, 32'h0800_0000, "srli_val");
        step(enc_i(32'h004, 5'd8, 3'b101, 5'd10, 7'h13), "srli");
        step(enc_i(32'd33, 5'd0, 3'b000, 5'd11, 7'h13), "addi_x11");
        expect_v(K_ADDR, 32'd2, "sll33_val");
        step(enc_r(7'h00, 5'd11, 5'd7, 3'b001, 5'd12), "sll33");
        expect_v(K_ADDR, 32'd2, "sub_val");
        step(enc_r(7'h20, 5'd6, 5'd7, 3'b000, 5'd13), "sub");
        expect_v(K_ADDR, 32'd1, "slt_val");
        step(enc_r(7'h00, 5'd7, 5'd6, 3'b010, 5'd13), "slt");
        expect_v(K_ADDR, 32'd0, "sltu_val");
        step(enc_r(7'h00, 5'd7, 5'd6, 3'b011, 5'd13), "sltu");
        expect_v(K_ADDR, 32'hFFFF_FFFE, "xor_val");
        step(enc_r(7'h00, 5'd7, 5'd6, 3'b100, 5'd13), "xor");
        expect_v(K_ADDR, exp_pc + 32'h1000, "auipc_val");
        step(enc_u(20'h00001, 5'd15, 7'h17), "auipc");
        step(enc_i(32'd9, 5'd0, 3'b000, 5'd0, 7'h13), "addi_x0");
        expect_v(K_DTW, 32'd0, "x0_zero");
        step(enc_s(32'd0, 5'd0, 5'd0, 3'b010), "sw_x0");

        // mid-run reset
        stepj(enc_i(32'h40, 5'd0, 3'b000, 5'd0, 7'h67), "jalr_40", 32'h40);
        reset = 1'b1;
        expect_v(K_WE, 32'd0, "rst_mid_we");
        stepj(enc_s(32'd0, 5'd2, 5'd0, 3'b010), "rst_mid", 32'h0);
        reset = 1'b0;
        expect_v(K_DTW, 32'd0, "rst_x2_clear");
        expect_v(K_WE, 32'd1, "rst_sw_we");
        step(enc_s(32'd0, 5'd2, 5'd0, 3'b010), "rst_sw_x2");
        expect_v(K_ADDR, 32'd0, "rst_x1_clear");
        step(enc_i(32'd0, 5'd1, 3'b000, 5'd0, 7'h13), "rst_rd_x1");

        // illegal / system opcodes behave as NOP
        expect_v(K_WE, 32'd0, "illegal_we");
        step(32'hFFFF_FFFF, "illegal");
        step(32'h0000_0073, "ecall");
        expect_v(K_DTW, 32'd0, "illegal_x31");
        step(enc_s(32'd0, 5'd31, 5'd0, 3'b010), "sw_x31");
        expect_v(K_PC, 32'h14, "final_pc");
        compare_all();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rv32i_single_cycle_core.md
Name: rv32i_single_cycle_core

Overview:
Single-cycle RV32I integer core. It fetches from an external combinational instruction memory and accesses an external word-organised data memory through a combinational read port and a synchronous write port. Every instruction completes in one clk cycle. The external harness owns memory, byte-lane alignment of store data, and test-result detection.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
instruction  input  32  instruction at address pc (combinational from instruction memory).
read_data  input  32  full aligned data-memory word at memory_address[31:2] (combinational).
pc  output  32  byte address of the current instruction.
memory_address  output  32  byte address for load/store (rs1 + imm); ALU result otherwise.
data_to_write  output  32  rs2 value, unshifted; harness aligns it by memory_address[1:0].
func3  output  3  instruction[14:12], always driven.
write_data  output  1  data-memory write enable; high only for store instructions.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset (reset=1 at posedge):
  - pc <= RESET_PC.
  - x1..x31 <= 0.
  - While reset is high, write_data=0 and no register write occurs.
  - Reset can arrive mid-program; the next cycle restarts from RESET_PC with a cleared register file.
- State:
  - 32-bit pc.
  - 32x32 register file, two combinational read ports, one write port written on posedge.
  - x0 reads 0; writes to x0 are ignored.
- Per cycle: decode, read registers, ALU, memory access, writeback, pc update. All outputs are combinational from current state and inputs.
- Supported instructions (full RV32I base):
  - Arithmetic/logic and upper-immediate: LUI, AUIPC, ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND and their immediate forms.
  - Shift-immediates use shamt = instruction[24:20]; SRAI is selected by instruction[30].
  - Arithmetic is 32-bit, wrapping; overflow is ignored.
  - SLT is signed, SLTU unsigned.
  - Shifts use the low 5 bits of the shift amount.
- Immediates:
  - I, S, B, U and J formats decoded and sign-extended per the RISC-V spec.
  - B and J offsets have bit0 = 0.
- Branches (BEQ/BNE/BLT/BGE/BLTU/BGEU):
  - Taken: pc <= pc + immB.
  - Not taken: pc <= pc + 4.
- Jumps (rd <= pc + 4 for both):
  - JAL: pc <= pc + immJ.
  - JALR: pc <= (rs1 + immI) & ~1. rs1 is read before the rd write takes effect.
- Loads (LB/LH/LW/LBU/LHU):
  - memory_address = rs1 + immI.
  - Select from read_data by memory_address[1:0]: byte lane = addr[1:0]; halfword lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW takes the whole word.
  - Misaligned accesses are not trapped; the lane is selected from addr bits as above.
- Stores (SB/SH/SW):
  - memory_address = rs1 + immS.
  - data_to_write = rs2.
  - write_data = 1; no register write.
  - Byte-strobe generation is external, using func3[1:0] and memory_address[1:0].
- All other instructions, including FENCE, ECALL, EBREAK, CSR and illegal opcodes:
  - Executed as NOP: pc <= pc + 4, no register write, write_data = 0.
- No traps, interrupts, stalls or handshakes. Latency is 1 cycle per instruction; a register result is visible to the next instruction.
- pc wraps modulo 2^32.

Test Plan:
1. Hold reset 2 cycles, release -> pc=0. Program "addi x1,x0,5; addi x2,x1,-7" -> after 2 cycles x2=0xFFFFFFFE, pc=8.
2. Pass signature: "addi x5,x0,1; sb x5,-1(x0)" -> in cycle 2, memory_address=0xFFFFFFFF, func3=000, write_data=1, data_to_write=1.
3. Loads, with read_data=0x8081_7F02 and base address 0x100:
   - lb @0x101 -> 0x7F.
   - lb @0x103 -> 0xFFFFFF80.
   - lbu @0x103 -> 0x80.
   - lh @0x102 -> 0xFFFF8081.
   - lw @0x100 -> 0x80817F02.
4. Branches/jumps:
   - bne x0,x0,+8 not taken (pc+4); blt with -1 < 1 taken; bltu with 0xFFFFFFFF < 1 not taken.
   - jal x1,+16 from pc=0x20 -> pc=0x30, x1=0x24.
   - jalr x0,3(x1) -> pc=0x26.
5. Shifts and writes to x0:
   - sra 0x80000000 by 4 -> 0xF8000000.
   - srl 0x80000000 by 4 -> 0x08000000.
   - sll by 33 -> shift by 1.
   - addi x0,x0,9 leaves x0=0.
6. Mid-run reset: assert reset while pc=0x40 -> next pc=0, registers read 0, write_data=0 during reset. Illegal opcode 0xFFFFFFFF -> pc+4, no side effects.
